// File: rtl/uart_pkg.sv
// Purpose: shared UART types and helpers used by the receiver and the future transmitter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package uart_pkg;

  // Parity mode encoding matches the PARITY parameter value (0/1/2).
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_t;

  // Widest legal data word; narrower words are zero-extended, which leaves the XOR unchanged.
  localparam int MAX_DATA_WIDTH = 9;

  // Parity bit a transmitter would send for this word.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input parity_t mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) p = ~p;
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: oversampling tick generator, one-cycle tick every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
// Latency: first tick TICK_DIV cycles after clear is released (every cycle when TICK_DIV = 1).
// Backpressure: none; free-running, realigned by clear.
// Ports: clk, rstn (async active-low), clear (restart the divider), tick (1-cycle strobe).
module uart_baud_tick #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  // A divide-by-one counter still needs one bit to exist.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV == 0) begin : g_bad_div
    $error("uart_baud_tick: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Purpose: oversampling UART receiver with majority vote, false-start rejection, parity and 1/2 stop bits.
// Latency: SYNC_STAGES cycles into the line synchroniser; valid rises 1 cycle after the final stop-bit vote.
// Backpressure: valid/ready; a frame completing while an unaccepted word is held is dropped and sets sticky overrun.
// Ports: clk, rstn (async active-low), rx_sig (raw line, idle high), data/valid/ready (output word handshake),
//        frame_err/parity_err (qualify data while valid), overrun (sticky, cleared by the next transfer).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_dw
    $error("uart_rx_os: DATA_WIDTH must be 5..9");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_os: SYNC_STAGES must be at least 2");
  end

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  // Three samples straddle the bit centre; the vote happens on the last of them.
  localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_VOTE = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH);
  localparam parity_t PAR_MODE = parity_t'(PARITY[1:0]);

  // Input synchroniser, reset to the idle-high line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_sig};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  rx_state_t                   state;
  logic                        rx_prev;
  logic [OSW-1:0]              os_cnt;
  logic [BCW-1:0]              bit_cnt;
  logic [DATA_WIDTH-1:0]       shift_reg;
  logic                        smp0, smp1;
  logic                        frame_err_tmp, parity_err_tmp;
  logic                        tick, clear, fall, vote, at_vote, at_end, par_bad;
  logic                        done, done_fe;
  logic [MAX_DATA_WIDTH-1:0]   shift_ext;

  // rx_prev follows the line in every state, so a line still low after a
  // frame (break) cannot look like a new falling edge.
  assign fall    = rx_prev & ~rx_s;
  assign clear   = (state == ST_IDLE) && fall;
  assign vote    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign at_vote = tick && (os_cnt == OS_VOTE);
  assign at_end  = tick && (os_cnt == OS_LAST);

  assign shift_ext = MAX_DATA_WIDTH'(shift_reg);
  assign par_bad   = vote ^ calc_parity(shift_ext, PAR_MODE);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clear(clear),
    .tick (tick)
  );

  // The frame completes on the last stop-bit vote rather than the bit end,
  // leaving half a bit of slack before a back-to-back start edge.
  always_comb begin
    done    = 1'b0;
    done_fe = 1'b0;
    case (state)
      ST_STOP: begin
        if (at_vote && STOP_BITS == 1) begin
          done    = 1'b1;
          done_fe = ~vote;
        end
      end
      ST_STOP2: begin
        if (at_vote) begin
          done    = 1'b1;
          done_fe = frame_err_tmp | ~vote;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      rx_prev        <= 1'b1;
      os_cnt         <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      smp0           <= 1'b0;
      smp1           <= 1'b0;
      frame_err_tmp  <= 1'b0;
      parity_err_tmp <= 1'b0;
      data           <= '0;
      valid          <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      rx_prev <= rx_s;

      if (tick && state != ST_IDLE) begin
        if (os_cnt == OS_S0) smp0 <= rx_s;
        if (os_cnt == OS_S1) smp1 <= rx_s;
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state          <= ST_START;
            os_cnt         <= '0;
            bit_cnt        <= '0;
            frame_err_tmp  <= 1'b0;
            parity_err_tmp <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state <= ST_IDLE;       // glitch, not a start bit
          end else if (at_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_vote) begin
            shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          if (at_end && bit_cnt == BIT_LAST) begin
            state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_vote) parity_err_tmp <= par_bad;
          if (at_end)  state <= ST_STOP;
        end
        ST_STOP: begin
          if (at_vote) begin
            frame_err_tmp <= ~vote;
            if (STOP_BITS == 1) state <= ST_IDLE;
          end else if (at_end) begin
            state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (at_vote) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Output word register: a completing frame wins over a plain transfer.
      if (done) begin
        if (!valid || ready) begin
          data       <= shift_reg;
          frame_err  <= done_fe;
          parity_err <= parity_err_tmp;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
